// File: rtl/csr_pkg.sv
// Shared CSR definitions for the trap unit: addresses, write masks, cause codes
// and the compact mstatus state type.
package csr_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    CSR_OP_RW = 2'b01,
    CSR_OP_RS = 2'b10,
    CSR_OP_RC = 2'b11
  } csr_op_e;

  // Only the implemented mstatus fields are stored; everything else reads as 0.
  typedef struct packed {
    priv_e mpp;
    logic  mpie;
    logic  mie;
  } mstatus_t;

  localparam logic [11:0] CSR_MSTATUS      = 12'h300;
  localparam logic [11:0] CSR_MIE          = 12'h304;
  localparam logic [11:0] CSR_MTVEC        = 12'h305;
  localparam logic [11:0] CSR_MHPMEVENT3   = 12'h323;
  localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [11:0] CSR_MEPC         = 12'h341;
  localparam logic [11:0] CSR_MCAUSE       = 12'h342;
  localparam logic [11:0] CSR_MTVAL        = 12'h343;
  localparam logic [11:0] CSR_MIP          = 12'h344;
  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3 = 12'hB03;
  localparam logic [11:0] CSR_MHARTID      = 12'hF14;

  localparam logic [63:0] WMASK_MSTATUS = 64'h0000_0000_0000_1888;
  localparam logic [63:0] WMASK_MIE     = 64'h0000_0000_0000_0888;
  localparam logic [63:0] WMASK_MTVEC   = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] WMASK_MEPC    = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] WMASK_FULL    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] WMASK_NONE    = 64'h0000_0000_0000_0000;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  function automatic logic [12:0] mstatus_pack(input mstatus_t s);
    return {s.mpp, 3'b000, s.mpie, 3'b000, s.mie, 3'b000};
  endfunction

endpackage

// File: rtl/csr_counters.sv
// Counter bank: mcycle, minstret and the mhpmcounter/mhpmevent pairs.
// A CSR write to a counter in the same cycle overrides its increment.
module csr_counters
  import csr_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_HPM = 2,
  localparam int HPM_W  = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            retire,
  input  logic [HPM_W-1:0] hpm_event,
  input  logic            wen,
  input  logic [11:0]     waddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] mcycle,
  output logic [XLEN-1:0] minstret,
  output logic [XLEN-1:0] hpm_count [HPM_W],
  output logic [XLEN-1:0] hpm_sel   [HPM_W]
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wen && waddr == CSR_MCYCLE) mcycle <= wdata;
      else                            mcycle <= mcycle + XLEN'(1);
      if (wen && waddr == CSR_MINSTRET) minstret <= wdata;
      else if (retire)                  minstret <= minstret + XLEN'(1);
    end
  end

  for (genvar i = 0; i < HPM_W; i++) begin : g_hpm
    if (i < NUM_HPM) begin : g_on
      logic [XLEN-1:0] cnt;
      logic [XLEN-1:0] sel;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
          sel <= '0;
        end else begin
          if (wen && waddr == CSR_MHPMEVENT3 + 12'(i)) sel <= wdata;
          if (wen && waddr == CSR_MHPMCOUNTER3 + 12'(i)) cnt <= wdata;
          else if (hpm_event[i] && sel != '0)            cnt <= cnt + XLEN'(1);
        end
      end

      assign hpm_count[i] = cnt;
      assign hpm_sel[i]   = sel;
    end else begin : g_off
      assign hpm_count[i] = '0;
      assign hpm_sel[i]   = '0;
    end
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return and interrupt arbitration.
// Event priority: exception > taken interrupt > mret > CSR write.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_HPM = 2,
  localparam int HPM_W  = (NUM_HPM > 0) ? NUM_HPM : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             csr_valid,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [XLEN-1:0]  csr_wdata,
  input  logic             csr_wen,
  output logic [XLEN-1:0]  csr_rdata,
  output logic             csr_illegal,
  input  logic             retire,
  input  logic [HPM_W-1:0] hpm_event,
  input  logic             exc_valid,
  input  logic [3:0]       exc_cause,
  input  logic [XLEN-1:0]  exc_pc,
  input  logic [XLEN-1:0]  exc_tval,
  input  logic             mret,
  input  logic             irq_msip,
  input  logic             irq_mtip,
  input  logic             irq_meip,
  input  logic             irq_take,
  input  logic [XLEN-1:0]  irq_pc,
  output logic             irq_pending,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       priv
);

  priv_e           priv_q;
  mstatus_t        mstatus_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mcycle, minstret;
  logic [XLEN-1:0] hpm_count [HPM_W];
  logic [XLEN-1:0] hpm_sel   [HPM_W];

  logic [XLEN-1:0] mip, irq_en, mtvec_base, trap_pc, trap_cause;
  logic [XLEN-1:0] rdata_mux, wmask, wr_raw, wr_val;
  logic [3:0]      irq_cause;
  logic            impl, take_exc, take_irq, do_mret, trap, csr_write;

  function automatic logic [XLEN-1:0] csr_apply(input logic [1:0] op,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] operand);
    case (op)
      CSR_OP_RW: return operand;
      CSR_OP_RS: return old | operand;
      CSR_OP_RC: return old & ~operand;
      default:   return old;
    endcase
  endfunction

  assign mip    = XLEN'({irq_meip, 3'b000, irq_mtip, 3'b000, irq_msip, 3'b000});
  assign irq_en = mip & mie_q;
  assign irq_cause = irq_en[11] ? CAUSE_MEI : (irq_en[3] ? CAUSE_MSI : CAUSE_MTI);

  assign irq_pending = !rst && (|irq_en) && (priv_q == PRIV_U || mstatus_q.mie);
  assign take_exc    = !rst && exc_valid;
  assign take_irq    = !rst && !exc_valid && irq_take && irq_pending;
  assign do_mret     = !rst && !exc_valid && !take_irq && mret;
  assign trap        = take_exc || take_irq;

  assign redirect_valid = trap || do_mret;
  assign mtvec_base     = mtvec_q & ~XLEN'(3);
  assign redirect_pc    = do_mret                 ? mepc_q :
                          (take_irq && mtvec_q[0]) ? mtvec_base + XLEN'({irq_cause, 2'b00}) :
                                                     mtvec_base;

  assign trap_pc    = take_exc ? exc_pc : irq_pc;
  assign trap_cause = take_irq ? ({1'b1, {(XLEN-1){1'b0}}} | XLEN'(irq_cause))
                               : XLEN'(exc_cause);

  always_comb begin
    rdata_mux = '0;
    impl      = 1'b1;
    wmask     = XLEN'(WMASK_FULL);
    case (csr_addr)
      CSR_MSTATUS:  begin rdata_mux = XLEN'(mstatus_pack(mstatus_q)); wmask = XLEN'(WMASK_MSTATUS); end
      CSR_MIE:      begin rdata_mux = mie_q;   wmask = XLEN'(WMASK_MIE);   end
      CSR_MTVEC:    begin rdata_mux = mtvec_q; wmask = XLEN'(WMASK_MTVEC); end
      CSR_MSCRATCH: rdata_mux = mscratch_q;
      CSR_MEPC:     begin rdata_mux = mepc_q;  wmask = XLEN'(WMASK_MEPC);  end
      CSR_MCAUSE:   rdata_mux = mcause_q;
      CSR_MTVAL:    rdata_mux = mtval_q;
      CSR_MIP:      begin rdata_mux = mip;     wmask = XLEN'(WMASK_NONE);  end
      CSR_MCYCLE:   rdata_mux = mcycle;
      CSR_MINSTRET: rdata_mux = minstret;
      CSR_MHARTID:  wmask = XLEN'(WMASK_NONE);
      default:      impl = 1'b0;
    endcase
    for (int i = 0; i < NUM_HPM; i++) begin
      if (csr_addr == CSR_MHPMCOUNTER3 + 12'(i)) begin rdata_mux = hpm_count[i]; impl = 1'b1; end
      if (csr_addr == CSR_MHPMEVENT3 + 12'(i))   begin rdata_mux = hpm_sel[i];   impl = 1'b1; end
    end
  end

  assign csr_rdata   = rdata_mux;
  assign csr_illegal = !rst && csr_valid &&
                       (!impl || (csr_wen && csr_addr[11:10] == 2'b11) ||
                        (priv_q == PRIV_U && csr_addr[9:8] == 2'b11));
  assign csr_write   = csr_valid && csr_wen && !csr_illegal && !trap && !do_mret;
  assign wr_raw      = csr_apply(csr_op, rdata_mux, csr_wdata);
  assign wr_val      = wr_raw & wmask;
  assign priv        = priv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_q     <= PRIV_M;
      mstatus_q  <= '{mpp: PRIV_U, mpie: 1'b0, mie: 1'b0};
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (trap) begin
      mepc_q         <= trap_pc & XLEN'(WMASK_MEPC);
      mcause_q       <= trap_cause;
      mtval_q        <= take_exc ? exc_tval : '0;
      mstatus_q.mpie <= mstatus_q.mie;
      mstatus_q.mie  <= 1'b0;
      mstatus_q.mpp  <= priv_q;
      priv_q         <= PRIV_M;
    end else if (do_mret) begin
      mstatus_q.mie  <= mstatus_q.mpie;
      mstatus_q.mpie <= 1'b1;
      mstatus_q.mpp  <= PRIV_U;
      priv_q         <= mstatus_q.mpp;
    end else if (csr_write) begin
      case (csr_addr)
        // MPP only holds U or M; any nonzero write selects M.
        CSR_MSTATUS:  mstatus_q <= '{mpp:  (wr_val[12:11] != 2'b00) ? PRIV_M : PRIV_U,
                                     mpie: wr_val[7], mie: wr_val[3]};
        CSR_MIE:      mie_q      <= wr_val;
        CSR_MTVEC:    mtvec_q    <= {wr_val[XLEN-1:2], 1'b0, wr_raw[1:0] == 2'b01};
        CSR_MSCRATCH: mscratch_q <= wr_val;
        CSR_MEPC:     mepc_q     <= wr_val;
        CSR_MCAUSE:   mcause_q   <= wr_val;
        CSR_MTVAL:    mtval_q    <= wr_val;
        default: ;
      endcase
    end
  end

  csr_counters #(
    .XLEN    (XLEN),
    .NUM_HPM (NUM_HPM)
  ) u_counters (
    .clk       (clk),
    .rst       (rst),
    .retire    (retire),
    .hpm_event (hpm_event),
    .wen       (csr_write),
    .waddr     (csr_addr),
    .wdata     (wr_val),
    .mcycle    (mcycle),
    .minstret  (minstret),
    .hpm_count (hpm_count),
    .hpm_sel   (hpm_sel)
  );

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: expected values are queued with the
// stimulus and popped when the DUT output is sampled.
module tb_csr_trap_unit;
  import csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid, csr_wen, retire, exc_valid, mret;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata, exc_pc, exc_tval, irq_pc, redirect_pc;
  logic        csr_illegal, irq_pending, redirect_valid;
  logic [1:0]  hpm_event, priv;
  logic [3:0]  exc_cause;
  logic        irq_msip, irq_mtip, irq_meip, irq_take;

  csr_trap_unit #(.XLEN(64), .NUM_HPM(2)) dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .retire(retire), .hpm_event(hpm_event),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .exc_tval(exc_tval), .mret(mret),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .irq_take(irq_take), .irq_pc(irq_pc),
    .irq_pending(irq_pending), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .priv(priv)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] rd_v;
  logic        ill_v;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] got);
    exp_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.tag = "sb_empty";
      e.val = 'x;
    end
    chk_eq(e.tag, got, e.val);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] wd, input logic wen, input bit commit);
    csr_valid = 1'b1;
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    csr_wen   = wen;
    #1;
    rd_v  = csr_rdata;
    ill_v = csr_illegal;
    if (commit) tick();
    csr_valid = 1'b0;
    csr_wen   = 1'b0;
  endtask

  task automatic wr_csr(input logic [1:0] op, input logic [11:0] addr, input logic [63:0] v);
    csr_acc(op, addr, v, 1'b1, 1'b1);
  endtask

  task automatic exp_csr(input string tag, input logic [11:0] addr, input logic [63:0] v);
    sb_push(tag, v);
    csr_acc(CSR_OP_RS, addr, 64'h0, 1'b0, 1'b0);
    sb_pop(rd_v);
  endtask

  task automatic exp_sig(input string tag, input logic [63:0] v, input logic [63:0] got);
    sb_push(tag, v);
    sb_pop(got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    csr_valid = 0; csr_wen = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    retire = 0; hpm_event = 0; exc_valid = 0; exc_cause = 0; exc_pc = 0;
    exc_tval = 0; mret = 0; irq_msip = 0; irq_mtip = 0; irq_meip = 0;
    irq_take = 0; irq_pc = 0;
    repeat (2) @(negedge clk);

    // Outputs held quiet during reset even with requests present
    exc_valid = 1; irq_take = 1; mret = 1;
    csr_valid = 1; csr_addr = 12'h7FF; csr_wen = 1;
    #1;
    exp_sig("rst_redirect", 64'd0, 64'(redirect_valid));
    exp_sig("rst_illegal",  64'd0, 64'(csr_illegal));
    exp_sig("rst_irq_pend", 64'd0, 64'(irq_pending));
    exp_sig("rst_priv",     64'd3, 64'(priv));
    exc_valid = 0; irq_take = 0; mret = 0; csr_valid = 0; csr_wen = 0;
    rst = 1'b0;

    repeat (10) @(negedge clk);
    exp_csr("mcycle_10", CSR_MCYCLE, 64'd10);
    exp_csr("mstatus_rst", CSR_MSTATUS, 64'h0);
    wr_csr(CSR_OP_RW, CSR_MCYCLE, 64'd5);
    exp_csr("mcycle_wr5", CSR_MCYCLE, 64'd5);

    // RW / RS / RC semantics on a full-width register
    wr_csr(CSR_OP_RW, CSR_MSCRATCH, 64'hF0);
    sb_push("rs_old_value", 64'hF0);
    csr_acc(CSR_OP_RS, CSR_MSCRATCH, 64'h0F, 1'b1, 1'b1);
    sb_pop(rd_v);
    wr_csr(CSR_OP_RC, CSR_MSCRATCH, 64'h3C);
    exp_csr("mscratch_rc", CSR_MSCRATCH, 64'hC3);

    // Read-only and unimplemented addresses
    sb_push("mhartid_rd_ill", 64'd0);
    csr_acc(CSR_OP_RS, CSR_MHARTID, 64'h0, 1'b0, 1'b0);
    sb_pop(64'(ill_v));
    sb_push("mhartid_wr_ill", 64'd1);
    csr_acc(CSR_OP_RW, CSR_MHARTID, 64'h5, 1'b1, 1'b1);
    sb_pop(64'(ill_v));
    sb_push("unimpl_ill", 64'd1);
    csr_acc(CSR_OP_RS, 12'h7C0, 64'h0, 1'b0, 1'b0);
    sb_pop(64'(ill_v));

    // mip mirrors lines and ignores writes
    wr_csr(CSR_OP_RW, CSR_MIP, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_csr("mip_ro", CSR_MIP, 64'h0);
    irq_msip = 1;
    exp_csr("mip_msip", CSR_MIP, 64'h8);
    irq_msip = 0;

    // minstret wrap and write-over-increment
    wr_csr(CSR_OP_RW, CSR_MINSTRET, 64'hFFFF_FFFF_FFFF_FFFF);
    retire = 1;
    tick();
    retire = 0;
    exp_csr("minstret_wrap", CSR_MINSTRET, 64'h0);
    retire = 1;
    wr_csr(CSR_OP_RW, CSR_MINSTRET, 64'd7);
    retire = 0;
    exp_csr("minstret_wr7", CSR_MINSTRET, 64'd7);

    // hpm counters gated by their event selector
    hpm_event = 2'b11;
    repeat (3) tick();
    hpm_event = 2'b00;
    exp_csr("hpm3_gated", CSR_MHPMCOUNTER3, 64'd0);
    wr_csr(CSR_OP_RW, CSR_MHPMEVENT3, 64'd1);
    hpm_event = 2'b11;
    repeat (3) tick();
    hpm_event = 2'b00;
    exp_csr("hpm3_count", CSR_MHPMCOUNTER3, 64'd3);
    exp_csr("hpm4_gated", CSR_MHPMCOUNTER3 + 12'd1, 64'd0);

    // mtvec MODE legalisation
    wr_csr(CSR_OP_RW, CSR_MTVEC, 64'h2002);
    exp_csr("mtvec_mode2", CSR_MTVEC, 64'h2000);
    wr_csr(CSR_OP_RW, CSR_MTVEC, 64'h3003);
    exp_csr("mtvec_mode3", CSR_MTVEC, 64'h3000);
    wr_csr(CSR_OP_RW, CSR_MTVEC, 64'h1001);
    exp_csr("mtvec_vect", CSR_MTVEC, 64'h1001);

    // Vectored timer interrupt; a simultaneous CSR write loses
    wr_csr(CSR_OP_RW, CSR_MIE, 64'h80);
    wr_csr(CSR_OP_RS, CSR_MSTATUS, 64'h8);
    irq_mtip = 1;
    #1;
    exp_sig("mti_pending", 64'd1, 64'(irq_pending));
    irq_take = 1; irq_pc = 64'h80;
    csr_valid = 1; csr_op = CSR_OP_RW; csr_addr = CSR_MSCRATCH;
    csr_wdata = 64'hDEAD; csr_wen = 1;
    #1;
    exp_sig("mti_redir_v", 64'd1, 64'(redirect_valid));
    exp_sig("mti_redir_pc", 64'h101C, redirect_pc);
    tick();
    irq_take = 0; csr_valid = 0; csr_wen = 0;
    exp_csr("mti_mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
    exp_csr("mti_mepc", CSR_MEPC, 64'h80);
    exp_csr("mti_mstatus", CSR_MSTATUS, 64'h1880);
    exp_csr("mti_csr_lost", CSR_MSCRATCH, 64'hC3);
    exp_sig("mti_masked", 64'd0, 64'(irq_pending));
    irq_mtip = 0;

    // All three pending: external wins; mepc low bits cleared
    wr_csr(CSR_OP_RW, CSR_MIE, 64'h888);
    wr_csr(CSR_OP_RS, CSR_MSTATUS, 64'h8);
    irq_msip = 1; irq_mtip = 1; irq_meip = 1;
    irq_take = 1; irq_pc = 64'h103;
    #1;
    exp_sig("mei_redir_pc", 64'h102C, redirect_pc);
    tick();
    irq_take = 0; irq_msip = 0; irq_mtip = 0; irq_meip = 0;
    exp_csr("mei_mcause", CSR_MCAUSE, 64'h8000_0000_0000_000B);
    exp_csr("mei_mepc", CSR_MEPC, 64'h100);
    exp_csr("mei_mstatus", CSR_MSTATUS, 64'h1880);

    // Drop to U through mret with MPP=U
    wr_csr(CSR_OP_RC, CSR_MSTATUS, 64'h1800);
    exp_csr("mstatus_mpp_u", CSR_MSTATUS, 64'h80);
    mret = 1;
    #1;
    exp_sig("mret1_pc", 64'h100, redirect_pc);
    tick();
    mret = 0;
    exp_sig("mret1_priv", 64'd0, 64'(priv));

    // M-level CSRs are illegal from U and leave state untouched
    sb_push("u_mstatus_ill", 64'd1);
    csr_acc(CSR_OP_RC, CSR_MSTATUS, 64'h8, 1'b1, 1'b1);
    sb_pop(64'(ill_v));
    sb_push("u_mcycle_ill", 64'd1);
    csr_acc(CSR_OP_RS, CSR_MCYCLE, 64'h0, 1'b0, 1'b0);
    sb_pop(64'(ill_v));

    // Exception beats a same-cycle mret
    exc_valid = 1; exc_cause = 4'd8; exc_pc = 64'h200; exc_tval = 64'h55; mret = 1;
    #1;
    exp_sig("exc_redir_v", 64'd1, 64'(redirect_valid));
    exp_sig("exc_redir_pc", 64'h1000, redirect_pc);
    tick();
    exc_valid = 0; mret = 0;
    exp_sig("exc_priv", 64'd3, 64'(priv));
    exp_csr("exc_mepc", CSR_MEPC, 64'h200);
    exp_csr("exc_mcause", CSR_MCAUSE, 64'h8);
    exp_csr("exc_mtval", CSR_MTVAL, 64'h55);
    exp_csr("exc_mstatus", CSR_MSTATUS, 64'h80);
    mret = 1;
    #1;
    exp_sig("mret2_pc", 64'h200, redirect_pc);
    tick();
    mret = 0;
    exp_sig("mret2_priv", 64'd0, 64'(priv));

    // Reset in the middle of a trap cycle aborts it
    exc_valid = 1; exc_cause = 4'd2; exc_pc = 64'h400;
    #1;
    rst = 1;
    #1;
    exp_sig("midrst_redir", 64'd0, 64'(redirect_valid));
    tick();
    exc_valid = 0;
    rst = 0;
    exp_sig("midrst_priv", 64'd3, 64'(priv));
    exp_csr("midrst_mepc", CSR_MEPC, 64'h0);
    exp_csr("midrst_mcause", CSR_MCAUSE, 64'h0);
    exp_csr("midrst_mtvec", CSR_MTVEC, 64'h0);

    chk_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the datapath and CSR width.
REQ-002 SHALL have parameter NUM_HPM, default 2, range 0..4, giving the number of mhpmcounter3+i / mhpmevent3+i pairs.
REQ-003 SHALL have ports: clk  in  1  clock; rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: csr_valid  in  1  CSR access request; csr_op  in  2  01=RW 10=RS 11=RC; csr_addr  in  12  CSR address; csr_wdata  in  XLEN  operand; csr_wen  in  1  write intended (0 for RS/RC with x0 source).
REQ-005 SHALL have ports: csr_rdata  out  XLEN  old value; csr_illegal  out  1  access fault.
REQ-006 SHALL have ports: retire  in  1  one instruction retired; hpm_event  in  NUM_HPM (min 1)  per-counter event pulses.
REQ-007 SHALL have ports: exc_valid  in  1  synchronous exception; exc_cause  in  4; exc_pc  in  XLEN; exc_tval  in  XLEN; mret  in  1.
REQ-008 SHALL have ports: irq_msip, irq_mtip, irq_meip  in  1 each  interrupt lines; irq_take  in  1  core accepts pending interrupt at irq_pc; irq_pc  in  XLEN.
REQ-009 SHALL have ports: irq_pending  out  1; redirect_valid  out  1; redirect_pc  out  XLEN; priv  out  2  current mode (0=U, 3=M).

Function
REQ-010 csr_rdata and csr_illegal SHALL be combinational from csr_addr and current state; CSR writes SHALL commit at the next rising edge.
REQ-011 New value SHALL be wdata (RW), old|wdata (RS), old&~wdata (RC), then ANDed with that CSR's write mask; csr_wen=0 SHALL suppress the write.
REQ-012 csr_illegal SHALL assert for unimplemented addresses, writes to read-only addresses (addr[11:10]==2'b11, e.g. mhartid), and M-level addresses while priv==U; an illegal access SHALL modify no state.
REQ-013 mcycle SHALL increment every cycle; minstret SHALL increment on retire; mhpmcounter3+i SHALL increment on hpm_event[i] when mhpmevent3+i != 0; a same-cycle CSR write to a counter SHALL take precedence over its increment; all counters SHALL wrap from 2^XLEN-1 to 0.
REQ-014 irq_pending SHALL equal |(mip & mie) && (priv==U || mstatus.MIE); mip.MSIP/MTIP/MEIP SHALL mirror the input lines and be read-only.
REQ-015 Trap entry (exc_valid, or irq_take with irq_pending) SHALL set mepc=pc with bits[1:0] cleared, mcause, mtval (exc_tval; 0 for interrupts), MPIE=MIE, MIE=0, MPP=priv, priv=M.
REQ-016 Interrupt cause priority SHALL be MEI(11) > MSI(3) > MTI(7); mcause[XLEN-1]=1 for interrupts.
REQ-017 redirect_pc SHALL be mtvec.BASE for exceptions and for interrupts when mtvec.MODE=0, and BASE+4*cause when MODE=1; MODE values 2/3 SHALL be written as 0.
REQ-018 mret SHALL set MIE=MPIE, MPIE=1, priv=MPP, MPP=U, redirect_pc=mepc.
REQ-019 redirect_valid SHALL be combinational, asserted in the cycle of trap entry or mret.
REQ-020 Simultaneous events SHALL resolve exc_valid > irq_take > mret > CSR write; the losers SHALL have no effect except counter increments.

Reset
REQ-021 On rst all CSRs and counters SHALL clear to 0 and priv SHALL become M (3); irq_pending, redirect_valid and csr_illegal SHALL be 0 while rst is held.
REQ-022 Reset asserted mid-trap SHALL abort the trap with no partial update.

Structure
REQ-023 CSR addresses, per-CSR write masks, cause codes and the mstatus field typedef SHALL live in the shared csr_pkg.
REQ-024 The counter bank SHALL be a separate sub-module csr_counters, parameterised by XLEN and NUM_HPM.

Verification
REQ-025 Reset, then read mcycle after 10 idle cycles -> 10; write mcycle=5, read next cycle -> 5.
REQ-026 priv=U, CSRRS mstatus -> csr_illegal=1, mstatus unchanged; CSRRW mhartid in M -> csr_illegal=1.
REQ-027 mtvec=0x1001, mie.MTIE=1, MIE=1, irq_mtip=1, irq_take at irq_pc=0x80 -> redirect_pc=0x101C, mcause=0x8000_0000_0000_0007, mepc=0x80, MIE=0.
REQ-028 exc_valid (cause 8, pc 0x200) with mret in the same cycle -> trap wins, mepc=0x200, then mret -> redirect_pc=0x200 and priv=MPP.
REQ-029 With msip, mtip and meip all pending and enabled, irq_take -> mcause low bits = 11.
REQ-030 minstret=2^XLEN-1 with retire=1 -> 0 next cycle; a same-cycle write of 7 -> 7.
